// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W    = 9;
    localparam int unsigned INSTR_W = 16;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // ROM fill / reset pattern, shown on o_instr whenever the queue is empty.
    localparam instr_t NOP_INSTR = 16'hF000;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
    } q_entry_t;

endpackage

// File: rtl/fetch_q2.sv
// Two-entry {instr, pc} FIFO. Slot 0 is always the head and is a register,
// so the head outputs are glitch-free. Empty slots hold {NOP_INSTR, RESET_PC}.
module fetch_q2
    import fetch_pkg::*;
#(
    parameter pc_t RESET_PC = 9'h000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  q_entry_t   i_data,
    output q_entry_t   o_head,
    output logic [1:0] o_occ
);

    localparam q_entry_t EMPTY_E = '{instr: NOP_INSTR, pc: RESET_PC};

    q_entry_t   slot0_q, slot1_q;
    q_entry_t   slot0_d, slot1_d;
    logic [1:0] occ_q, occ_d;

    // Next-state: pop shifts slot 1 forward, push lands at the new tail,
    // flush overrides both and leaves the queue empty.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_d   = occ_q;

        if (i_pop && occ_q != 2'd0) begin
            slot0_d = (occ_q == 2'd2) ? slot1_q : EMPTY_E;
            slot1_d = EMPTY_E;
            occ_d   = occ_q - 2'd1;
        end

        if (i_push && occ_d != 2'd2) begin
            if (occ_d == 2'd0) begin
                slot0_d = i_data;
            end else begin
                slot1_d = i_data;
            end
            occ_d = occ_d + 2'd1;
        end

        if (i_flush) begin
            slot0_d = EMPTY_E;
            slot1_d = EMPTY_E;
            occ_d   = 2'd0;
        end
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot0_q <= EMPTY_E;
            slot1_q <= EMPTY_E;
            occ_q   <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            occ_q   <= occ_d;
        end
    end

    assign o_head = slot0_q;
    assign o_occ  = occ_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues ROM reads, reassembles the
// 16-bit instruction from the byte lanes and buffers it for decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter pc_t RESET_PC = 9'h000
) (
    input  logic   i_clk,
    input  logic   i_rst,
    output logic   o_rom_en,
    output pc_t    o_rom_addr,
    input  logic [7:0] i_rom_dout_h,
    input  logic [7:0] i_rom_dout_l,
    input  logic   i_redirect,
    input  pc_t    i_redirect_pc,
    output logic   o_valid,
    input  logic   i_ready,
    output instr_t o_instr,
    output pc_t    o_instr_pc
);

    pc_t        pc_q;
    pc_t        issued_pc_q;
    logic       inflight_q;
    logic [1:0] occ;
    logic [2:0] committed;
    logic       pop;
    logic       issue;
    logic       push;
    q_entry_t   head;
    q_entry_t   push_data;

    assign o_valid   = (occ != 2'd0);
    assign pop       = o_valid && i_ready;

    // Queue slots already spoken for: entries held plus the read in flight.
    assign committed = {1'b0, occ} + {2'b00, inflight_q};
    assign issue     = !i_rst && (i_redirect || committed < 3'd2 || pop);

    assign o_rom_en   = issue;
    assign o_rom_addr = i_redirect ? i_redirect_pc : pc_q;

    // A redirect makes the returning read stale, so capture is suppressed.
    assign push      = inflight_q && !i_redirect;
    assign push_data = '{instr: {i_rom_dout_h, i_rom_dout_l}, pc: issued_pc_q};

    // PC, issued address and inflight tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q        <= o_rom_addr + 9'd1;
                issued_pc_q <= o_rom_addr;
            end
        end
    end

    fetch_q2 #(
        .RESET_PC (RESET_PC)
    ) u_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .i_data  (push_data),
        .o_head  (head),
        .o_occ   (occ)
    );

    assign o_instr    = head.instr;
    assign o_instr_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic, all checked against a queue-based model.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst, redir, ready, chk_en;
    pc_t    rpc;
    logic [7:0] dh, dl, dhw, dlw;
    logic   en, en_w, valid, valid_w;
    pc_t    addr, addr_w, ipc, ipc_w;
    instr_t instr, instr_w;

    instr_t mem [512];
    logic [15:0] rq, rqw;

    // ROM: data for the address issued in one cycle is visible in the next.
    always @(posedge clk) if (en)   rq  <= mem[addr];
    always @(posedge clk) if (en_w) rqw <= mem[addr_w];
    assign dh  = rq[15:8];
    assign dl  = rq[7:0];
    assign dhw = rqw[15:8];
    assign dlw = rqw[7:0];

    instr_fetch u_dut (
        .i_clk(clk), .i_rst(rst), .o_rom_en(en), .o_rom_addr(addr),
        .i_rom_dout_h(dh), .i_rom_dout_l(dl), .i_redirect(redir),
        .i_redirect_pc(rpc), .o_valid(valid), .i_ready(ready),
        .o_instr(instr), .o_instr_pc(ipc)
    );

    instr_fetch #(.RESET_PC(9'h1FE)) u_wrap (
        .i_clk(clk), .i_rst(rst), .o_rom_en(en_w), .o_rom_addr(addr_w),
        .i_rom_dout_h(dhw), .i_rom_dout_l(dlw), .i_redirect(1'b0),
        .i_redirect_pc(9'h000), .o_valid(valid_w), .i_ready(1'b1),
        .o_instr(instr_w), .o_instr_pc(ipc_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of {instr, pc} visible to decode, plus the
    // address of the read currently in flight.
    logic [24:0] mq[$];
    pc_t  mpc   = 9'h000;
    pc_t  miss  = 9'h000;
    logic minfl = 1'b0;

    function automatic logic m_issue();
        return !rst && (redir || (mq.size() + int'(minfl) < 2) || (mq.size() > 0 && ready));
    endfunction

    function automatic pc_t m_addr();
        return redir ? rpc : mpc;
    endfunction

    task automatic model_step();
        logic iss;
        pc_t  a;
        if (rst) begin
            mq.delete();
            minfl = 1'b0;
            mpc   = 9'h000;
        end else begin
            iss = m_issue();
            a   = m_addr();
            if (mq.size() > 0 && ready) void'(mq.pop_front());
            if (redir) mq.delete();
            else if (minfl) mq.push_back({mem[miss], miss});
            if (iss) begin
                miss = a;
                mpc  = a + 9'd1;
            end
            minfl = iss;
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("instr", {16'd0, instr}, {16'd0, mq[0][24:9]});
                chk("instr_pc", {23'd0, ipc}, {23'd0, mq[0][8:0]});
            end else begin
                chk("instr_empty", {16'd0, instr}, 32'h0000F000);
            end
            chk("rom_en", {31'd0, en}, {31'd0, m_issue()});
            chk("rom_addr", {23'd0, addr}, {23'd0, m_addr()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
    endtask

    initial begin
        rst = 1'b1; redir = 1'b0; rpc = '0; ready = 1'b1; chk_en = 1'b0;
        for (int unsigned i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0125 + 16'h3C5A);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

        // Reset state
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'h0000F000);
        chk("rst_pc", {23'd0, ipc}, 32'h000);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_wrap_pc", {23'd0, ipc_w}, 32'h1FE);
        cyc();
        rst = 1'b0;                                  // C0
        @(negedge clk);
        chk("c0_en", {31'd0, en}, 32'd1);
        chk("c0_addr", {23'd0, addr}, 32'h000);
        chk("c0_wrap_addr", {23'd0, addr_w}, 32'h1FE);
        cyc();                                       // C1
        @(negedge clk);
        chk("c1_valid", {31'd0, valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin            // C2..C5
            cyc();
            @(negedge clk);
            chk("stream_valid", {31'd0, valid}, 32'd1);
            chk("stream_instr", {16'd0, instr}, {16'd0, mem[k]});
            chk("stream_pc", {23'd0, ipc}, k);
            chk("wrap_pc", {23'd0, ipc_w}, {23'd0, pc_t'(9'h1FE + k)});
            chk("wrap_instr", {16'd0, instr_w}, {16'd0, mem[pc_t'(9'h1FE + k)]});
        end

        // Stall C6..C10
        for (int k = 0; k < 5; k++) begin
            cyc();
            ready = 1'b0;
            @(negedge clk);
            chk("stall_instr", {16'd0, instr}, {16'd0, mem[4]});
        end
        chk("stall_en", {31'd0, en}, 32'd0);
        chk("stall_pc", {23'd0, ipc}, 32'd4);
        for (int k = 4; k < 8; k++) begin            // C11..C14
            cyc();
            ready = 1'b1;
            @(negedge clk);
            chk("resume_instr", {16'd0, instr}, {16'd0, mem[k]});
            chk("resume_pc", {23'd0, ipc}, k);
        end

        // Redirect with no pop
        cyc();                                       // C15
        ready = 1'b0; redir = 1'b1; rpc = 9'h100;
        @(negedge clk);
        chk("redir_addr", {23'd0, addr}, 32'h100);
        cyc();                                       // C16
        ready = 1'b1; redir = 1'b0;
        @(negedge clk);
        chk("redir_n1_valid", {31'd0, valid}, 32'd0);
        chk("redir_n1_instr", {16'd0, instr}, 32'h0000F000);
        cyc();                                       // C17
        @(negedge clk);
        chk("redir_n2_valid", {31'd0, valid}, 32'd1);
        chk("redir_n2_pc", {23'd0, ipc}, 32'h100);
        chk("redir_n2_instr", {16'd0, instr}, {16'd0, mem[9'h100]});
        cyc();                                       // C18
        @(negedge clk);
        chk("redir_n3_pc", {23'd0, ipc}, 32'h101);

        // Redirect coinciding with pop (target also wraps)
        cyc();                                       // C19
        redir = 1'b1; rpc = 9'h1FE;
        @(negedge clk);
        chk("rpop_pc", {23'd0, ipc}, 32'h102);
        cyc();                                       // C20
        redir = 1'b0;
        @(negedge clk);
        chk("rpop_n1_valid", {31'd0, valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin            // C21..C23
            cyc();
            @(negedge clk);
            chk("rpop_pc_seq", {23'd0, ipc}, {23'd0, pc_t'(9'h1FE + k)});
        end

        // Reset mid-stream with stall and inflight read
        cyc();
        ready = 1'b0; rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_instr", {16'd0, instr}, 32'h0000F000);
        chk("mrst_en", {31'd0, en}, 32'd0);
        cyc();
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        chk("mrst_addr", {23'd0, addr}, 32'h000);
        cyc();
        cyc();
        @(negedge clk);
        chk("mrst_instr2", {16'd0, instr}, 32'h00001111);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst   = ($urandom_range(99) == 0);
            redir = ($urandom_range(19) == 0);
            rpc   = pc_t'($urandom);
            ready = ($urandom_range(9) < 7);
        end
        cyc();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
